fact_host: RTL and testbench



---
 rtl/fact_host.sv | 183 ++++++++++++++++++
 tb/tb_fact_host.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fact_host.sv
// fact_host: bus-master sequencer for the memory-mapped factorial accelerator.
// It runs one computation at a time: write n, write go, poll status, then read
// the result. Requests and responses use a valid/ready interface.
// Optional feature macro: FACT_HOST_TIMEOUT_EN adds a poll counter that
// abandons a run after TIMEOUT_CYCLES poll cycles without Done or Err.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. rsp_valid stays high, with
// rsp_result/rsp_err/rsp_timeout stable, until the edge where rsp_ready is high.
module fact_host #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [1:0]  A,
  output logic        WE,
  output logic [3:0]  WD,
  input  logic [31:0] RD,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_POLL   = 3'd3,
    S_RD_RES = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

`ifdef FACT_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Poll-cycle index of the last poll allowed before giving up.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`else
  // TIMEOUT_CYCLES has no effect in this build; referenced here only so the
  // parameter is not reported as dangling.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // State and datapath registers; reset returns to an idle, quiet bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= 4'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
`ifdef FACT_HOST_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef FACT_HOST_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Next-state and datapath updates for the register protocol.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef FACT_HOST_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          n_d     = req_n;
          state_d = S_WR_N;
        end
      end
      S_WR_N:  state_d = S_WR_GO;
      S_WR_GO: begin
`ifdef FACT_HOST_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_POLL;
      end
      S_POLL: begin
        // Err beats Done; either beats the timeout on the same cycle.
        if (RD[1]) begin
          err_d    = 1'b1;
          result_d = 32'd0;
`ifdef FACT_HOST_TIMEOUT_EN
          tmo_d    = 1'b0;
`endif
          state_d  = S_RESP;
        end else if (RD[0]) begin
          state_d = S_RD_RES;
        end else begin
`ifdef FACT_HOST_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            err_d    = 1'b1;
            tmo_d    = 1'b1;
            result_d = 32'd0;
            state_d  = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      S_RD_RES: begin
        result_d = RD;
        err_d    = 1'b0;
`ifdef FACT_HOST_TIMEOUT_EN
        tmo_d    = 1'b0;
`endif
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and handshake outputs decoded purely from the state register.
  always_comb begin
    A         = 2'd0;
    WE        = 1'b0;
    WD        = 4'd0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_WR_N: begin
        A  = 2'd0;
        WE = 1'b1;
        WD = n_q;
      end
      S_WR_GO: begin
        A  = 2'd1;
        WE = 1'b1;
        WD = 4'b0001;
      end
      S_POLL:   A = 2'd2;
      S_RD_RES: A = 2'd3;
      S_RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state_q;
`ifdef FACT_HOST_TIMEOUT_EN
  assign rsp_timeout = tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fact_host.sv
// Testbench for fact_host with a behavioural accelerator slave. The slave
// completes a configurable number of cycles after the go write; the expected
// response comes from a plain factorial model of the accelerator.
module tb_fact_host;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_n = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  A;
  logic        WE;
  logic [3:0]  WD;
  logic [31:0] rd;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [5:0]  wr_log[$];
  int          poll_cnt = 0;
  int          rd3_cnt  = 0;

  // slave configuration: latency in poll cycles, mode 0 normal (Err for n>12),
  // mode 1 never completes, mode 2 raises Err and Done together
  int          slv_lat  = 1;
  int          slv_mode = 0;
  logic [3:0]  s_n      = 4'd0;
  logic        s_go     = 1'b0;
  logic [1:0]  s_status = 2'b00;
  logic [31:0] s_result = 32'd0;
  int          s_cnt    = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        tmo;
    int          cyc;
    int          polls;
    int          reads;
    int          nwr;
    logic [5:0]  w0;
    logic [5:0]  w1;
    bit          ok;
    bit          stable;
  } obs_t;

  fact_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .A(A), .WE(WE), .WD(WD), .RD(rd), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // reference model of the accelerator's arithmetic
  function automatic logic [31:0] fact32(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  function automatic logic [1:0] fin_status(input logic [3:0] n, input int mode);
    if (mode == 1) return 2'b00;
    if (mode == 2) return 2'b11;
    return (n > 4'd12) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] fin_result(input logic [3:0] n, input int mode);
    if (mode != 0 || n > 4'd12) return 32'hDEAD_BEEF;
    return fact32(int'(n));
  endfunction

  // behavioural slave: register file read combinationally from A
  always_comb begin
    case (A)
      2'd0:    rd = {28'd0, s_n};
      2'd1:    rd = {31'd0, s_go};
      2'd2:    rd = {30'd0, s_status};
      default: rd = s_result;
    endcase
  end

  always @(posedge clk) begin
    if (WE && A == 2'd0) s_n <= WD;
    if (WE && A == 2'd1) begin
      s_go <= WD[0];
      if (WD[0]) begin
        s_cnt <= slv_lat - 1;
        if (slv_lat == 1) begin
          s_status <= fin_status(s_n, slv_mode);
          s_result <= fin_result(s_n, slv_mode);
        end else begin
          s_status <= 2'b00;
        end
      end
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) begin
        s_status <= fin_status(s_n, slv_mode);
        s_result <= fin_result(s_n, slv_mode);
      end
    end
  end

  // bus monitor
  always @(posedge clk) begin
    if (WE) wr_log.push_back({A, WD});
    if (A == 2'd2) poll_cnt <= poll_cnt + 1;
    if (A == 2'd3) rd3_cnt <= rd3_cnt + 1;
  end

  // driver: present a request and complete its handshake
  task automatic send_req(input logic [3:0] n, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = n;
    for (int g = 0; g < 50; g++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      req_n = 4'($urandom_range(0, 15));
    end
    req_valid = 1'b0;
  endtask

  // driver: wait (bounded) for rsp_valid, counting cycles after the handshake
  task automatic wait_rsp(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // driver: one full transaction, returning what was observed
  task automatic run_txn(input logic [3:0] n, input int lat, input int mode,
                         input int hold, input bit keep_ready, output obs_t o);
    int base, p0, r0;
    o = '{default: 0};
    slv_lat  = lat;
    slv_mode = mode;
    base = wr_log.size();
    p0 = poll_cnt;
    r0 = rd3_cnt;
    send_req(n, o.ok);
    if (!o.ok) return;
    wait_rsp(3000, o.cyc, o.ok);
    if (!o.ok) return;
    o.res = rsp_result;
    o.err = rsp_err;
    o.tmo = rsp_timeout;
    o.stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== o.res || rsp_err !== o.err || rsp_timeout !== o.tmo)
        o.stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_ready) rsp_ready = 1'b0;
    o.polls = poll_cnt - p0;
    o.reads = rd3_cnt - r0;
    o.nwr   = wr_log.size() - base;
    if (o.nwr > 0) o.w0 = wr_log[base];
    if (o.nwr > 1) o.w1 = wr_log[base + 1];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #7;
    n_checks++;
    if ({req_ready, rsp_valid, busy, WE, A, WD} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b we=%b a=%0d wd=%0d expected 1 0 0 0 0 0",
               req_ready, rsp_valid, busy, WE, A, WD);
    end
    n_checks++;
    if ({rsp_result, rsp_err, rsp_timeout} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got result=%0d err=%b tmo=%b expected 0 0 0",
               rsp_result, rsp_err, rsp_timeout);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_n5();
    obs_t o;
    exp_q.push_back(fact32(5));
    run_txn(4'd5, 1, 0, 2, 1'b0, o);
    n_checks++;
    if (!o.ok) begin n_fail++; $display("FAIL n5_done: got no response expected response"); end
    n_checks++;
    if (o.res !== exp_q.pop_front() || o.err !== 1'b0 || o.tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL n5_rsp: got result=%0d err=%b tmo=%b expected 120 0 0", o.res, o.err, o.tmo);
    end
    n_checks++;
    if (o.cyc != 5) begin n_fail++; $display("FAIL n5_latency: got %0d expected 5", o.cyc); end
    n_checks++;
    if (o.nwr != 2 || o.w0 !== 6'h05 || o.w1 !== 6'h11) begin
      n_fail++;
      $display("FAIL n5_writes: got n=%0d w0=%h w1=%h expected 2 05 11", o.nwr, o.w0, o.w1);
    end
    n_checks++;
    if (o.reads != 1 || o.polls != 1) begin
      n_fail++;
      $display("FAIL n5_bus: got reads=%0d polls=%0d expected 1 1", o.reads, o.polls);
    end
    n_checks++;
    if (!o.stable) begin n_fail++; $display("FAIL n5_hold: got unstable response expected stable"); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [3:0] ns[2];
    int lats[2];
    ns[0] = 4'd0; ns[1] = 4'd3;
    lats[0] = 1;  lats[1] = 3;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(fact32(int'(ns[k])));
      run_txn(ns[k], lats[k], 0, 0, 1'b1, o);
      n_checks++;
      if (!o.ok || o.res !== exp_q.pop_front() || o.err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: got ok=%b result=%0d err=%b expected %0d 0",
                 k, o.ok, o.res, o.err, fact32(int'(ns[k])));
      end
      n_checks++;
      if (o.polls != lats[k] || o.cyc != 4 + lats[k]) begin
        n_fail++;
        $display("FAIL b2b_poll%0d: got polls=%0d cyc=%0d expected %0d %0d",
                 k, o.polls, o.cyc, lats[k], 4 + lats[k]);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_err_range();
    obs_t o;
    run_txn(4'd13, 2, 0, 1, 1'b0, o);
    n_checks++;
    if (!o.ok || o.res !== 32'd0 || o.err !== 1'b1 || o.tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL err13_rsp: got ok=%b result=%0d err=%b tmo=%b expected 0 1 0",
               o.ok, o.res, o.err, o.tmo);
    end
    n_checks++;
    if (o.reads != 0 || o.cyc != 5) begin
      n_fail++;
      $display("FAIL err13_bus: got reads=%0d cyc=%0d expected 0 5", o.reads, o.cyc);
    end
  endtask

  task automatic test_err_and_done();
    obs_t o;
    run_txn(4'd4, 3, 2, 0, 1'b0, o);
    n_checks++;
    if (!o.ok || o.res !== 32'd0 || o.err !== 1'b1 || o.reads != 0) begin
      n_fail++;
      $display("FAIL errdone_rsp: got ok=%b result=%0d err=%b reads=%0d expected 0 1 0",
               o.ok, o.res, o.err, o.reads);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [3:0] n;
    int lat, hold;
    logic exp_err;
    for (int k = 0; k < 12; k++) begin
      n = 4'($urandom_range(0, 15));
      lat = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      exp_err = (n > 4'd12);
      exp_q.push_back(exp_err ? 32'd0 : fact32(int'(n)));
      run_txn(n, lat, 0, hold, 1'b0, o);
      n_checks++;
      if (!o.ok || o.res !== exp_q.pop_front() || o.err !== exp_err || o.tmo !== 1'b0 || !o.stable) begin
        n_fail++;
        $display("FAIL rand%0d_rsp n=%0d: got ok=%b result=%0d err=%b tmo=%b stable=%b expected err=%b",
                 k, n, o.ok, o.res, o.err, o.tmo, o.stable, exp_err);
      end
      n_checks++;
      if (o.cyc != (exp_err ? 3 : 4) + lat || o.polls != lat || o.reads != (exp_err ? 0 : 1)
          || o.nwr != 2 || o.w0 !== {2'd0, n} || o.w1 !== 6'h11) begin
        n_fail++;
        $display("FAIL rand%0d_bus n=%0d lat=%0d: got cyc=%0d polls=%0d reads=%0d nwr=%0d w0=%h w1=%h",
                 k, n, lat, o.cyc, o.polls, o.reads, o.nwr, o.w0, o.w1);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
`ifdef FACT_HOST_TIMEOUT_EN
    run_txn(4'd6, 1, 1, 0, 1'b0, o);
    n_checks++;
    if (!o.ok || o.res !== 32'd0 || o.err !== 1'b1 || o.tmo !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rsp: got ok=%b result=%0d err=%b tmo=%b expected 0 1 1",
               o.ok, o.res, o.err, o.tmo);
    end
    n_checks++;
    if (o.polls != 8 || o.cyc != 11) begin
      n_fail++;
      $display("FAIL timeout_polls: got polls=%0d cyc=%0d expected 8 11", o.polls, o.cyc);
    end
`else
    int cyc;
    bit ok, b_ok;
    slv_lat  = 1;
    slv_mode = 1;
    send_req(4'd6, ok);
    b_ok = ok;
    cyc = 0;
    while (cyc < 1100) begin
      @(negedge clk);
      cyc++;
      if (!busy || rsp_valid) b_ok = 1'b0;
    end
    n_checks++;
    if (!b_ok) begin
      n_fail++;
      $display("FAIL nolimit_busy: got busy dropped or response within %0d cycles expected busy throughout", cyc);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    o = '{default: 0};
`endif
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit ok;
    int cyc;
    // a response left waiting in RESP, then released
    slv_lat = 1;
    slv_mode = 0;
    send_req(4'd2, ok);
    wait_rsp(50, cyc, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || rsp_valid !== 1'b1 || rsp_result !== 32'd2) begin
      n_fail++;
      $display("FAIL resp_wait: got ok=%b vld=%b result=%0d expected 1 1 2", ok, rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    // reset while WE is high in WR_N
    slv_mode = 1;
    send_req(4'd7, ok);
    n_checks++;
    if (WE !== 1'b1) begin n_fail++; $display("FAIL wr_n_we: got %b expected 1", WE); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (WE !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_n: got we=%b busy=%b rdy=%b expected 0 0 1", WE, busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    // reset while polling
    send_req(4'd7, ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (A !== 2'd2) begin n_fail++; $display("FAIL poll_addr: got %0d expected 2", A); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (WE !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || A !== 2'd0 || rsp_result !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_poll: got we=%b vld=%b rdy=%b a=%0d result=%0d expected 0 0 1 0 0",
               WE, rsp_valid, req_ready, A, rsp_result);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(fact32(4));
    run_txn(4'd4, 2, 0, 0, 1'b0, o);
    n_checks++;
    if (!o.ok || o.res !== exp_q.pop_front() || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_rst: got ok=%b result=%0d err=%b expected 24 0", o.ok, o.res, o.err);
    end
  endtask

  initial begin
    test_reset();
    test_n5();
    test_back_to_back();
    test_err_range();
    test_err_and_done();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
